mux_scan_sequencer: RTL and testbench



---
 rtl/mux_scan_sequencer.sv | 136 +++++++++++++
 tb/tb_mux_scan_sequencer.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/mux_scan_sequencer.sv
// rtl/mux_scan_sequencer.sv - masked ascending-order scan of a 4-to-1 mux onto a valid/ready stream
//
// Purpose:
//   Drives the select of an external combinational 4-to-1 mux. On start it walks
//   the lanes enabled in mask from lowest to highest index. Each mux output is
//   registered one cycle after the select changes and is presented on a
//   valid/ready output stream.
//
// Optional feature macro: MUX_SCAN_CHECKSUM_EN
//   When defined, adds a running XOR checksum output of every accepted word.
//
// Ports:
//   clk        in   clock, rising edge
//   rst        in   synchronous active-high reset
//   start      in   scan request, sampled only while idle
//   mask       in   lane enables (bit i -> mux input i), sampled with start
//   sel        out  mux select, wired to the mux c input
//   mux_z      in   mux output
//   out_data   out  captured word
//   out_sel    out  lane index that produced out_data
//   out_valid  out  out_data/out_sel valid
//   out_ready  in   consumer accepts on out_valid && out_ready
//   busy       out  high whenever a scan is in progress
//   done       out  one-cycle pulse at scan completion
//   checksum   out  XOR of accepted words (only with MUX_SCAN_CHECKSUM_EN)

module mux_scan_sequencer #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [3:0]       mask,
  output logic [1:0]       sel,
  input  logic [WIDTH-1:0] mux_z,
  output logic [WIDTH-1:0] out_data,
  output logic [1:0]       out_sel,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             busy,
  output logic             done
`ifdef MUX_SCAN_CHECKSUM_EN
  ,
  output logic [WIDTH-1:0] checksum
`endif
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CAPT = 2'd1,
    S_WAIT = 2'd2
  } state_t;

  state_t     state;
  logic [3:0] pend;   // lanes still to be emitted in this scan

  // Index of the lowest set bit; gives ascending lane order.
  function automatic logic [1:0] lowest_lane(input logic [3:0] m);
    logic [1:0] idx;
    idx = 2'd0;
    if (m[0])      idx = 2'd0;
    else if (m[1]) idx = 2'd1;
    else if (m[2]) idx = 2'd2;
    else if (m[3]) idx = 2'd3;
    return idx;
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      pend      <= 4'd0;
      sel       <= 2'd0;
      out_data  <= '0;
      out_sel   <= 2'd0;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
`ifdef MUX_SCAN_CHECKSUM_EN
      checksum  <= '0;
`endif
    end else begin
      // done is a single-cycle pulse unless re-armed below
      done <= 1'b0;

      case (state)
        S_IDLE: begin
          if (start) begin
`ifdef MUX_SCAN_CHECKSUM_EN
            checksum <= '0;
`endif
            if (mask != 4'd0) begin
              pend  <= mask;
              sel   <= lowest_lane(mask);
              busy  <= 1'b1;
              state <= S_CAPT;
            end else begin
              // Empty scan: complete immediately without emitting a word
              done <= 1'b1;
            end
          end
        end

        S_CAPT: begin
          // sel has been stable for a full cycle, so mux_z has settled
          out_data   <= mux_z;
          out_sel    <= sel;
          out_valid  <= 1'b1;
          pend[sel]  <= 1'b0;
          state      <= S_WAIT;
        end

        S_WAIT: begin
          if (out_ready) begin
            out_valid <= 1'b0;
`ifdef MUX_SCAN_CHECKSUM_EN
            checksum  <= checksum ^ out_data;
`endif
            if (pend != 4'd0) begin
              sel   <= lowest_lane(pend);
              state <= S_CAPT;
            end else begin
              done  <= 1'b1;
              busy  <= 1'b0;
              state <= S_IDLE;
            end
          end
        end

        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mux_scan_sequencer.sv
// tb/tb_mux_scan_sequencer.sv - randomized self-checking bench for mux_scan_sequencer
module tb_mux_scan_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [3:0]  mask;
  logic [1:0]  sel;
  logic [31:0] mux_z;
  logic [31:0] out_data;
  logic [1:0]  out_sel;
  logic        out_valid;
  logic        out_ready;
  logic        busy;
  logic        done;
`ifdef MUX_SCAN_CHECKSUM_EN
  logic [31:0] checksum;
`endif

  logic [31:0] a [4];

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  // Combinational 4-to-1 mux standing in for yMux4to1
  assign mux_z = a[sel];

  mux_scan_sequencer #(.WIDTH(32)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .mask      (mask),
    .sel       (sel),
    .mux_z     (mux_z),
    .out_data  (out_data),
    .out_sel   (out_sel),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .busy      (busy),
    .done      (done)
`ifdef MUX_SCAN_CHECKSUM_EN
    ,
    .checksum  (checksum)
`endif
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // mode 0: ready high; 1: random ready; 2: ready low for the first 5 valid
  // cycles; 3: ready high plus a stray start while busy.
  task automatic run_scan(input logic [3:0] m, input int mode);
    int          q_lane[$];
    logic [31:0] q_data[$];
    int          k, cycles, stalls, lowcnt, last;
    logic [31:0] ck;
    bit          hold, timed_out;
    logic [31:0] prev_data;
    logic [1:0]  prev_sel;
    k = 0; last = 0; ck = 32'd0;
    for (int i = 0; i < 4; i++) begin
      if (m[i]) begin
        q_lane.push_back(i);
        q_data.push_back(a[i]);
        ck ^= a[i];
        k++;
        last = i;
      end
    end
    @(negedge clk);
    start = 1'b1; mask = m; out_ready = 1'b1;
    cycles = 0; stalls = 0; lowcnt = 0; hold = 0; timed_out = 0;
    prev_data = 32'd0; prev_sel = 2'd0;
    while (1) begin
      @(negedge clk);
      cycles++;
      start = (mode == 3 && cycles == 2);
      mask  = 4'($urandom_range(0, 15));
      if (hold) begin
        check("hold_valid", out_valid, 1);
        check("hold_data", out_data, prev_data);
        check("hold_sel", out_sel, prev_sel);
      end
      if (done) break;
      check("busy_during", busy, 1);
      if (mode == 1) out_ready = 1'($urandom_range(0, 1));
      else if (mode == 2 && out_valid && lowcnt < 5) begin
        out_ready = 1'b0;
        lowcnt++;
      end else out_ready = 1'b1;
      hold = 0;
      if (out_valid) begin
        if (q_lane.size() == 0) check("extra_word", out_valid, 0);
        else if (!out_ready) begin
          stalls++;
          hold = 1;
          prev_data = out_data;
          prev_sel = out_sel;
        end else begin
          check("lane", out_sel, q_lane[0]);
          check("data", out_data, q_data[0]);
          void'(q_lane.pop_front());
          void'(q_data.pop_front());
        end
      end
      if (cycles > 300) begin
        check("timeout", 1, 0);
        timed_out = 1;
        break;
      end
    end
    start = 1'b0;
    out_ready = 1'b1;
    if (!timed_out) begin
      check("done_cycle", cycles, 2 * k + 1 + stalls);
      check("busy_at_done", busy, 0);
      check("valid_at_done", out_valid, 0);
      check("words_left", q_lane.size(), 0);
      if (k > 0) check("sel_hold", sel, last);
`ifdef MUX_SCAN_CHECKSUM_EN
      check("checksum", checksum, ck);
`endif
      @(negedge clk);
      check("done_pulse", done, 0);
    end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; mask = 4'd0; out_ready = 1'b0;
    for (int i = 0; i < 4; i++) a[i] = 32'd0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("rst_sel", sel, 0);
    check("rst_out_data", out_data, 0);
    check("rst_out_sel", out_sel, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);

    // Full scan with fixed operands
    a[0] = 32'h11111111; a[1] = 32'h22222222; a[2] = 32'h33333333; a[3] = 32'h44444444;
    run_scan(4'hF, 0);
`ifdef MUX_SCAN_CHECKSUM_EN
    check("checksum_full", checksum, 32'h44444444);
`endif

    // Sparse mask
    a[0] = $urandom; a[1] = 32'hDEADBEEF; a[2] = $urandom; a[3] = 32'hCAFEF00D;
    run_scan(4'b1010, 0);

    // Backpressure on a single lane
    a[0] = $urandom;
    run_scan(4'h1, 2);

    // Empty scan
    run_scan(4'h0, 0);

    // Stray start while busy
    for (int i = 0; i < 4; i++) a[i] = $urandom;
    run_scan(4'hF, 3);

    // Reset in the wait state of lane 1
    @(negedge clk);
    start = 1'b1; mask = 4'hF; out_ready = 1'b1;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      start = 1'b0;
      if (out_valid && out_sel == 2'd1) break;
    end
    check("reach_lane1", out_sel, 1);
    out_ready = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    out_ready = 1'b1;
    check("mid_rst_sel", sel, 0);
    check("mid_rst_out_data", out_data, 0);
    check("mid_rst_out_sel", out_sel, 0);
    check("mid_rst_out_valid", out_valid, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_done", done, 0);
`ifdef MUX_SCAN_CHECKSUM_EN
    check("mid_rst_checksum", checksum, 0);
`endif
    @(negedge clk);
    check("mid_rst_no_done", done, 0);
    run_scan(4'hF, 0);

    // Random scans
    for (int n = 0; n < 24; n++) begin
      for (int i = 0; i < 4; i++) a[i] = $urandom;
      run_scan(4'($urandom_range(0, 15)), $urandom_range(0, 3));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
